burst_main_memory: RTL and testbench

Next-generation main memory model behind the instruction and data caches. It is byte-addressed and big-endian: the lowest address maps to the data MSB. It adds a configurable beat width, multi-beat bursts, a programmable access latency and a registered request/finish handshake. It arbitrates between the i-cache and d-cache ports, grants one burst at a time, and reports completion with the existing `MEM_*` status encodings.

---
 rtl/burst_main_memory.sv | 208 ++++++++++++++++++++
 tb/tb_burst_main_memory.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_main_memory.sv
// Byte-addressed, big-endian burst main memory shared by the i-cache and d-cache.
// Define ARB_FAIR_EN to stop a busy d-cache from starving the i-cache.
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef MEM_RESTING
`define MEM_RESTING 2'b00
`endif
`ifndef MEM_INST_FINISHED
`define MEM_INST_FINISHED 2'b01
`endif
`ifndef MEM_DATA_FINISHED
`define MEM_DATA_FINISHED 2'b10
`endif
`ifndef ONE_BYTE
`define ONE_BYTE 3'd0
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'd1
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'd2
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'd3
`endif

module burst_main_memory #(
  parameter int ADDR_WIDTH       = 20,
  parameter int BYTE_SIZE        = 8,
  parameter int BEAT_BYTES       = 4,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int ACCESS_LATENCY   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [1:0]                       i_cache_mem_vis_signal,
  input  logic [1:0]                       d_cache_mem_vis_signal,
  input  logic [ADDR_WIDTH-1:0]            i_cache_mem_vis_addr,
  input  logic [ADDR_WIDTH-1:0]            d_cache_mem_vis_addr,
  input  logic [ENTRY_INDEX_SIZE:0]        length,
  input  logic [BEAT_BYTES*BYTE_SIZE-1:0]  written_data,
  input  logic [2:0]                       data_type,
  output logic [BEAT_BYTES*BYTE_SIZE-1:0]  mem_data,
  output logic                             mem_beat_valid,
  output logic [1:0]                       mem_status
);

  localparam int DW       = BEAT_BYTES * BYTE_SIZE;
  localparam int LW       = ENTRY_INDEX_SIZE + 1;
  localparam int CW       = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY + 1) : 1;
  localparam int MEM_SIZE = 1 << ADDR_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            r_state;
  logic                  r_owner_d;
  logic                  r_op_write;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LW-1:0]         r_beats;
  logic [LW-1:0]         r_k;
  logic [2:0]            r_dtype;
  logic [CW-1:0]         r_cnt;

  // NOTE: storage is deliberately left out of reset; a reset must not erase written bytes.
  logic [BYTE_SIZE-1:0]  r_mem [MEM_SIZE] = '{default: '0};

  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_grant_d;
  logic                  w_grant_i;
  logic [ADDR_WIDTH-1:0] w_beat_addr;
  logic [DW-1:0]         w_rd_data;
  logic                  w_last;
  logic                  w_wr_beat;
  int                    w_wr_bytes;

  // The i-cache may only read; its write requests are never granted.
  assign w_i_req = (i_cache_mem_vis_signal == `MEM_READ);
  assign w_d_req = (d_cache_mem_vis_signal == `MEM_READ) ||
                   (d_cache_mem_vis_signal == `MEM_WRITE);

`ifdef ARB_FAIR_EN
  logic [1:0] r_fair_cnt;
  logic       w_force_i;

  assign w_force_i = (r_fair_cnt == 2'd2) && w_i_req && w_d_req;
  assign w_grant_d = w_d_req && !w_force_i;
  assign w_grant_i = w_i_req && !w_grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fair_cnt <= 2'd0;
    end else if (r_state == IDLE) begin
      if (!w_d_req && !w_i_req) begin
        r_fair_cnt <= 2'd0;
      end else if (w_grant_i) begin
        r_fair_cnt <= 2'd0;
      end else if (w_grant_d && w_i_req && (r_fair_cnt != 2'd3)) begin
        r_fair_cnt <= r_fair_cnt + 2'd1;
      end
    end
  end
`else
  assign w_grant_d = w_d_req;
  assign w_grant_i = w_i_req && !w_d_req;
`endif

  assign w_beat_addr = r_base + ADDR_WIDTH'(int'(r_k) * BEAT_BYTES);
  assign w_last      = (r_k == r_beats - LW'(1));
  assign w_wr_beat   = (r_state == XFER) && r_op_write;

  function automatic int dtype_bytes(input logic [2:0] t);
    case (t)
      `ONE_BYTE:   return 1;
      `TWO_BYTE:   return 2;
      `FOUR_BYTE:  return 4;
      `EIGHT_BYTE: return 8;
      default:     return 0;
    endcase
  endfunction

  always_comb begin
    w_wr_bytes = dtype_bytes(r_dtype);
    if (w_wr_bytes > BEAT_BYTES) w_wr_bytes = BEAT_BYTES;
  end

  // Lowest address lands in the most significant byte lane.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      w_rd_data[DW-1-i*BYTE_SIZE -: BYTE_SIZE] = r_mem[w_beat_addr + ADDR_WIDTH'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_beat) begin
      for (int i = 0; i < BEAT_BYTES; i++) begin
        if (i < w_wr_bytes) begin
          r_mem[w_beat_addr + ADDR_WIDTH'(i)] <= written_data[DW-1-i*BYTE_SIZE -: BYTE_SIZE];
        end
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_owner_d      <= 1'b0;
      r_op_write     <= 1'b0;
      r_base         <= '0;
      r_beats        <= '0;
      r_k            <= '0;
      r_dtype        <= '0;
      r_cnt          <= '0;
      mem_data       <= '0;
      mem_beat_valid <= 1'b0;
      mem_status     <= `MEM_RESTING;
    end else begin
      mem_beat_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_owner_d  <= w_grant_d;
            r_op_write <= w_grant_d && (d_cache_mem_vis_signal == `MEM_WRITE);
            r_base     <= w_grant_d ? d_cache_mem_vis_addr : i_cache_mem_vis_addr;
            r_beats    <= (length == '0) ? LW'(1) : length;
            r_dtype    <= data_type;
            r_k        <= '0;
            r_cnt      <= CW'(ACCESS_LATENCY);
            r_state    <= (ACCESS_LATENCY == 0) ? XFER : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) r_state <= XFER;
        end
        XFER: begin
          if (!r_op_write) begin
            mem_data       <= w_rd_data;
            mem_beat_valid <= 1'b1;
          end
          if (w_last) begin
            mem_status <= r_owner_d ? `MEM_DATA_FINISHED : `MEM_INST_FINISHED;
            r_state    <= DONE;
          end else begin
            r_k <= r_k + LW'(1);
          end
        end
        default: begin
          mem_status <= `MEM_RESTING;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_main_memory.sv
// Directed bench for burst_main_memory: one instance at latency 2, one at latency 0.
`ifndef MEM_NOP
`define MEM_NOP 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef MEM_RESTING
`define MEM_RESTING 2'b00
`endif
`ifndef MEM_INST_FINISHED
`define MEM_INST_FINISHED 2'b01
`endif
`ifndef MEM_DATA_FINISHED
`define MEM_DATA_FINISHED 2'b10
`endif
`ifndef ONE_BYTE
`define ONE_BYTE 3'd0
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'd1
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'd2
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'd3
`endif

module tb_burst_main_memory;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int LW = 4;

`ifdef ARB_FAIR_EN
  localparam logic [1:0]  B3_STATUS = `MEM_INST_FINISHED;
  localparam logic [31:0] B3_DATA   = 32'h3333_3333;
`else
  localparam logic [1:0]  B3_STATUS = `MEM_DATA_FINISHED;
  localparam logic [31:0] B3_DATA   = 32'h0001_0203;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel;
  logic [1:0]    i_sig, d_sig, d_sig_a, d_sig_b;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] wdata;
  logic [2:0]    dtype;
  logic [DW-1:0] a_data, b_data, o_data;
  logic          a_valid, b_valid, o_valid;
  logic [1:0]    a_status, b_status, o_status;

  always #5 clk = ~clk;

  assign d_sig_a  = sel ? `MEM_NOP : d_sig;
  assign d_sig_b  = sel ? d_sig : `MEM_NOP;
  assign o_data   = sel ? b_data : a_data;
  assign o_valid  = sel ? b_valid : a_valid;
  assign o_status = sel ? b_status : a_status;

  burst_main_memory #(.ACCESS_LATENCY(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_cache_mem_vis_signal(i_sig), .d_cache_mem_vis_signal(d_sig_a),
    .i_cache_mem_vis_addr(i_addr), .d_cache_mem_vis_addr(d_addr),
    .length(len), .written_data(wdata), .data_type(dtype),
    .mem_data(a_data), .mem_beat_valid(a_valid), .mem_status(a_status)
  );

  burst_main_memory #(.ACCESS_LATENCY(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_cache_mem_vis_signal(`MEM_NOP), .d_cache_mem_vis_signal(d_sig_b),
    .i_cache_mem_vis_addr(i_addr), .d_cache_mem_vis_addr(d_addr),
    .length(len), .written_data(wdata), .data_type(dtype),
    .mem_data(b_data), .mem_beat_valid(b_valid), .mem_status(b_status)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_beats [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_read(input logic [AW-1:0] addr, input logic [LW-1:0] l);
    int n;
    int lat;
    n   = (l == '0) ? 1 : int'(l);
    lat = sel ? 0 : 2;
    d_sig = `MEM_READ; d_addr = addr; len = l;
    tick();
    d_sig = `MEM_NOP;
    for (int c = 1; c <= lat + n; c++) begin
      tick();
      check("rd_valid", o_valid, (c > lat));
      if (c > lat) check("rd_data", o_data, exp_beats[c-lat-1]);
      check("rd_status", o_status, (c == lat + n) ? `MEM_DATA_FINISHED : `MEM_RESTING);
    end
    tick();
    check("rd_valid_end", o_valid, 1'b0);
    check("rd_resting", o_status, `MEM_RESTING);
  endtask

  task automatic mem_write(input logic [AW-1:0] addr, input logic [LW-1:0] l, input logic [2:0] t);
    int n;
    int lat;
    n   = (l == '0) ? 1 : int'(l);
    lat = sel ? 0 : 2;
    d_sig = `MEM_WRITE; d_addr = addr; len = l; dtype = t;
    tick();
    d_sig = `MEM_NOP;
    for (int c = 1; c <= lat + n; c++) begin
      if (c > lat) wdata = exp_beats[c-lat-1];
      tick();
      check("wr_valid", o_valid, 1'b0);
      check("wr_status", o_status, (c == lat + n) ? `MEM_DATA_FINISHED : `MEM_RESTING);
    end
    tick();
    check("wr_resting", o_status, `MEM_RESTING);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    i_sig = `MEM_NOP; d_sig = `MEM_NOP;
    i_addr = '0; d_addr = '0; len = '0; wdata = '0; dtype = `FOUR_BYTE;
    tick(); tick();
    check("rst_status", a_status, `MEM_RESTING);
    check("rst_valid", a_valid, 1'b0);
    check("rst_data", a_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic two-beat write then read back at latency 2.
    exp_beats[0] = 32'h0001_0203; exp_beats[1] = 32'h0405_0607;
    mem_write(20'h00100, 4'd2, `FOUR_BYTE);
    mem_read(20'h00100, 4'd2);

    // Partial-width writes and an unknown data_type.
    exp_beats[0] = 32'hAABB_CCDD;
    mem_write(20'h00200, 4'd1, `TWO_BYTE);
    exp_beats[0] = 32'hAABB_0000;
    mem_read(20'h00200, 4'd1);
    exp_beats[0] = 32'h99FF_FFFF;
    mem_write(20'h00204, 4'd1, `ONE_BYTE);
    exp_beats[0] = 32'hFFFF_FFFF;
    mem_write(20'h00208, 4'd1, 3'd7);
    exp_beats[0] = 32'h9900_0000; exp_beats[1] = 32'h0000_0000;
    mem_read(20'h00204, 4'd2);

    // Address wrap at the top of memory.
    exp_beats[0] = 32'hDEAD_BEEF;
    mem_write(20'hFFFFC, 4'd1, `FOUR_BYTE);
    exp_beats[0] = 32'h0102_0304;
    mem_write(20'h00000, 4'd1, `FOUR_BYTE);
    exp_beats[0] = 32'hDEAD_BEEF; exp_beats[1] = 32'h0102_0304;
    mem_read(20'hFFFFC, 4'd2);

    exp_beats[0] = 32'h3333_3333;
    mem_write(20'h00300, 4'd1, `FOUR_BYTE);

    // Tie: d-cache first, waiting i-cache granted two edges after FINISHED.
    d_sig = `MEM_READ; d_addr = 20'h00100; i_sig = `MEM_READ; i_addr = 20'h00300; len = 4'd1;
    tick();
    d_sig = `MEM_NOP;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("arb_a_valid", a_valid, (c == 3) || (c == 8));
      if (c == 3) check("arb_a_data_d", a_data, 32'h0001_0203);
      if (c == 8) check("arb_a_data_i", a_data, 32'h3333_3333);
      check("arb_a_status", a_status,
            (c == 3) ? `MEM_DATA_FINISHED : (c == 8) ? `MEM_INST_FINISHED : `MEM_RESTING);
      if (c == 5) i_sig = `MEM_NOP;
    end
    tick(); tick();

    // Both ports re-requesting continuously.
    d_sig = `MEM_READ; i_sig = `MEM_READ;
    tick();
    for (int c = 1; c <= 14; c++) begin
      tick();
      check("arb_b_valid", a_valid, (c == 3) || (c == 8) || (c == 13));
      if (c == 3 || c == 8) check("arb_b_data_d", a_data, 32'h0001_0203);
      if (c == 13) check("arb_b_data_3", a_data, B3_DATA);
      check("arb_b_status", a_status,
            (c == 3 || c == 8) ? `MEM_DATA_FINISHED : (c == 13) ? B3_STATUS : `MEM_RESTING);
      if (c == 10) begin
        d_sig = `MEM_NOP; i_sig = `MEM_NOP;
      end
    end
    tick(); tick();

    // Reset during the third beat of a four-beat write.
    d_sig = `MEM_WRITE; d_addr = 20'h00400; len = 4'd4; dtype = `FOUR_BYTE;
    tick();
    d_sig = `MEM_NOP;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) wdata = 32'h1111_1111;
      if (c == 4) wdata = 32'h2222_2222;
      if (c == 5) begin
        wdata = 32'h3333_3333;
        rst_n = 1'b0;
      end
      tick();
    end
    check("abort_status", a_status, `MEM_RESTING);
    check("abort_valid", a_valid, 1'b0);
    check("abort_data", a_data, 32'h0);
    rst_n = 1'b1;
    tick();
    check("abort_idle", a_status, `MEM_RESTING);
    exp_beats[0] = 32'h1111_1111; exp_beats[1] = 32'h2222_2222;
    exp_beats[2] = 32'h0000_0000; exp_beats[3] = 32'h0000_0000;
    mem_read(20'h00400, 4'd4);

    // Zero latency, length 0 means one beat.
    sel = 1'b1;
    tick();
    exp_beats[0] = 32'h1122_3344;
    mem_write(20'h00010, 4'd0, `FOUR_BYTE);
    mem_read(20'h00010, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
